sce: RTL and testbench
======================

Name: sce

Overview:
- Signal Channel Encoder (SCE): the transmit-side counterpart of the SIGNAL channel decoder.
- Assembles the 24-bit 802.11a SIGNAL field from RATE and LENGTH, computes even parity and appends 6 tail zeros.
- Convolutionally encodes the field at rate 1/2, K=7, generators g0=133o and g1=171o.
- Emits the 48 coded bits serially, one per clock, toward the transmit interleaver/mapper.

Parameters:
None. The SIGNAL field format is fixed.

Ports:
- clk  in  1  working clock
- rst  in  1  reset, synchronous, active high
- rate  in  4  RATE field; rate[3]=R1 (transmitted first) .. rate[0]=R4
- len  in  12  LENGTH field in bytes; transmitted LSB first
- di_vld  in  1  start request; sampled together with rate/len
- rdy  out  1  high when idle and able to accept di_vld
- do  out  1  coded output bit
- do_vld  out  1  do is valid
- do_last  out  1  high with the 48th coded bit

Behaviour:
- Reset: all outputs are synchronous to clk. Reset values: rdy=1, do=0, do_vld=0, do_last=0. Encoder shift register is cleared to 0 and the FSM returns to IDLE. Reset mid-frame aborts the frame; no further do_vld until a new start.
- SIGNAL field, bit index 0..23 in transmit order:
  - b0..b3 = rate[3],rate[2],rate[1],rate[0]
  - b4 = 0 (reserved)
  - b5..b16 = len[0]..len[11]
  - b17 = XOR of b0..b16 (even parity)
  - b18..b23 = 0 (tail)
- The field is latched into a 24-bit register on the accepted start. Inputs rate and len are don't-care afterwards.
- Encoder state: d1..d6 = the previous 6 input bits, with d1 the most recent. All are zero at frame start.
  - A = x ^ d2 ^ d3 ^ d5 ^ d6 (g0=133o)
  - B = x ^ d1 ^ d2 ^ d3 ^ d6 (g1=171o)
  - The shift register advances once per input bit, after B is emitted.
- Output order: for each input bit x_i, A_i then B_i.
  - Coded bit 2i = A_i, coded bit 2i+1 = B_i, for i = 0..23.
  - Total 48 bits.
- FSM:
  - IDLE: rdy=1. On di_vld=1, latch the field, clear the shift register and go to ENC_A.
  - ENC_A: do=A_i, do_vld=1. Go to ENC_B.
  - ENC_B: do=B_i, do_vld=1. Shift x_i in and increment the bit counter (5 bits, 0..23).
    - If the counter was 23: do_last=1 and go to IDLE.
    - Otherwise: go to ENC_A.
- Timing:
  - di_vld accepted at cycle T makes the first do_vld appear at T+1.
  - do_vld is continuous for 48 cycles (T+1..T+48), with no gaps.
  - do_last is asserted at T+48.
  - rdy is 0 from T+1 through T+48 and returns to 1 at T+49.
  - Back-to-back frames: a new di_vld at T+49 gives the next first bit at T+50.
- Other conditions:
  - di_vld while rdy=0 is ignored; there is no queueing.
  - di_vld together with rst: rst wins.
  - do=0 whenever do_vld=0.

Test Plan:
1. Reset, then rate=4'b1011, len=12'd100, di_vld pulse → first 8 coded bits 1,1,0,1,0,0,0,1; parity b17=0; 48 do_vld cycles; do_last on the 48th; rdy high on the following cycle.
2. rate=0, len=0 → all 48 coded bits 0; do_last after exactly 48 valid cycles.
3. rate=4'b1101, len=0 → b17=1. Compare all 48 bits against a software 133/171 encoder model; the last 12 coded bits are driven only by parity and tail bits.
4. Back-to-back: the second di_vld in the same cycle rdy rises; a di_vld pulsed mid-frame → ignored, frame still exactly 48 bits, second frame bit-exact with fresh zero encoder state.
5. Assert rst at coded bit 20 → do_vld=0 and rdy=1 on the next cycle. A new start then produces a correct full frame, with no carry-over of state.
6. Random rate/len (≥1000 frames) through SCE → SCD loopback → SCD output equals the 24 SIGNAL bits from the model.

Source files
------------

// File: rtl/sce.sv
// SIGNAL channel encoder (SCE).
// Builds the 24-bit 802.11a SIGNAL field from RATE/LENGTH (even parity plus six
// tail zeros), encodes it with the rate-1/2 K=7 convolutional code (g0=133o,
// g1=171o) and streams the 48 coded bits out serially, one per clock.
//
// Ports:
//   clk     working clock
//   rst     synchronous reset, active high
//   rate    RATE field, rate[3]=R1 is transmitted first
//   len     LENGTH field in bytes, transmitted LSB first
//   di_vld  start request, sampled together with rate/len while rdy=1
//   rdy     idle and able to accept di_vld
//   do_bit  coded output bit (the name "do" is a reserved SystemVerilog keyword)
//   do_vld  do_bit is valid
//   do_last high with the 48th coded bit
module sce (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rate,
  input  logic [11:0] len,
  input  logic        di_vld,
  output logic        rdy,
  output logic        do_bit,
  output logic        do_vld,
  output logic        do_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC_A = 2'd1,
    ENC_B = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] field;      // field[i] = SIGNAL bit b_i in transmit order
  logic [5:0]  sr;         // sr[0]=d1 (most recent input) .. sr[5]=d6
  logic [4:0]  cnt;        // index of the input bit being encoded
  logic [23:0] field_new;
  logic        x;
  logic        coded_a;
  logic        coded_b;
  logic        last_bit;

  // SIGNAL field assembly from the live inputs; only latched on an accepted start.
  always_comb begin
    field_new        = '0;
    field_new[0]     = rate[3];
    field_new[1]     = rate[2];
    field_new[2]     = rate[1];
    field_new[3]     = rate[0];
    field_new[4]     = 1'b0;
    field_new[16:5]  = len;
    field_new[17]    = ^{rate, len};
    field_new[23:18] = '0;
  end

  assign x        = field[cnt];
  assign coded_a  = x ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
  assign coded_b  = x ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
  assign last_bit = (cnt == 5'd23);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      field <= '0;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && di_vld) begin
        field <= field_new;
        sr    <= '0;
        cnt   <= '0;
      end else if (state == ENC_B) begin
        sr  <= {sr[4:0], x};
        cnt <= last_bit ? 5'd0 : cnt + 5'd1;
      end
    end
  end

  // Outputs decode the registered state directly, so they are quiet in IDLE.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    do_bit    = 1'b0;
    do_vld    = 1'b0;
    do_last   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (di_vld) state_nxt = ENC_A;
      end
      ENC_A: begin
        do_bit    = coded_a;
        do_vld    = 1'b1;
        state_nxt = ENC_B;
      end
      ENC_B: begin
        do_bit    = coded_b;
        do_vld    = 1'b1;
        do_last   = last_bit;
        state_nxt = last_bit ? IDLE : ENC_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sce.sv
// Self-checking bench for sce: directed frames, reset abort, back-to-back and
// ignored mid-frame starts, then random frames checked against a generator-mask
// convolutional model and an inverse-feedback decoder loopback.
module tb_sce;

  logic        clk;
  logic        rst;
  logic [3:0]  rate;
  logic [11:0] len;
  logic        di_vld;
  logic        rdy;
  logic        do_bit;
  logic        do_vld;
  logic        do_last;

  int checks   = 0;
  int failures = 0;

  sce dut (
    .clk     (clk),
    .rst     (rst),
    .rate    (rate),
    .len     (len),
    .di_vld  (di_vld),
    .rdy     (rdy),
    .do_bit  (do_bit),
    .do_vld  (do_vld),
    .do_last (do_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SIGNAL field as a bit array in transmit order.
  function automatic logic [23:0] model_field(input logic [3:0] r, input logic [11:0] l);
    logic [23:0] b;
    logic p;
    b = '0;
    for (int k = 0; k < 4; k++)  b[k] = r[3-k];
    for (int k = 0; k < 12; k++) b[5+k] = l[k];
    p = 1'b0;
    for (int k = 0; k < 17; k++) p = p ^ b[k];
    b[17] = p;
    return b;
  endfunction

  // Convolutional encoder from the octal generators: tap g[6-k] weights x_{i-k}.
  function automatic logic [47:0] model_encode(input logic [23:0] b);
    logic [6:0]  g0;
    logic [6:0]  g1;
    logic [47:0] c;
    logic a, bb;
    g0 = 7'o133;
    g1 = 7'o171;
    c  = '0;
    for (int i = 0; i < 24; i++) begin
      a  = 1'b0;
      bb = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (i - k >= 0) begin
          a  = a  ^ (g0[6-k] & b[i-k]);
          bb = bb ^ (g1[6-k] & b[i-k]);
        end
      end
      c[2*i]   = a;
      c[2*i+1] = bb;
    end
    return c;
  endfunction

  // Recovers the input bits from the A stream by cancelling the known history.
  function automatic logic [23:0] loop_decode(input logic [47:0] c);
    logic [23:0] x;
    logic h;
    x = '0;
    for (int i = 0; i < 24; i++) begin
      h = 1'b0;
      if (i >= 2) h = h ^ x[i-2];
      if (i >= 3) h = h ^ x[i-3];
      if (i >= 5) h = h ^ x[i-5];
      if (i >= 6) h = h ^ x[i-6];
      x[i] = c[2*i] ^ h;
    end
    return x;
  endfunction

  // Starts one frame from a cycle where rdy is expected high and collects the
  // coded bits. glitch_at pulses di_vld during that coded bit; rst_at aborts.
  task automatic run_frame(input logic [3:0] r, input logic [11:0] l,
                           input int glitch_at, input int rst_at,
                           input string tag, output logic [47:0] got);
    chk({tag, "_rdy_pre"}, 64'(rdy), 64'd1);
    rate   = r;
    len    = l;
    di_vld = 1'b1;
    @(posedge clk); #1;
    di_vld = 1'b0;
    rate   = 4'($urandom);
    len    = 12'($urandom);
    got    = '0;
    for (int i = 0; i < 48; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, "_rst_vld"},  64'(do_vld), 64'd0);
        chk({tag, "_rst_rdy"},  64'(rdy),    64'd1);
        chk({tag, "_rst_do"},   64'(do_bit), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_rst_quiet"}, 64'(do_vld), 64'd0);
        return;
      end
      chk({tag, "_vld"},  64'(do_vld),  64'd1);
      chk({tag, "_rdy"},  64'(rdy),     64'd0);
      chk({tag, "_last"}, 64'(do_last), 64'(i == 47));
      got[i] = do_bit;
      if (i == glitch_at)     di_vld = 1'b1;
      if (i == glitch_at + 1) di_vld = 1'b0;
      if (i < 47) begin
        @(posedge clk); #1;
      end
    end
    di_vld = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle_rdy"},  64'(rdy),     64'd1);
    chk({tag, "_idle_vld"},  64'(do_vld),  64'd0);
    chk({tag, "_idle_last"}, 64'(do_last), 64'd0);
    chk({tag, "_idle_do"},   64'(do_bit),  64'd0);
    chk({tag, "_bits"}, 64'(got), 64'(model_encode(model_field(r, l))));
  endtask

  initial begin
    logic [47:0] got;
    logic [3:0]  r;
    logic [11:0] l;

    rst    = 1'b1;
    di_vld = 1'b0;
    rate   = '0;
    len    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy",  64'(rdy),     64'd1);
    chk("reset_vld",  64'(do_vld),  64'd0);
    chk("reset_last", 64'(do_last), 64'd0);
    chk("reset_do",   64'(do_bit),  64'd0);

    // start request coinciding with reset is dropped
    di_vld = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    di_vld = 1'b0;
    chk("rst_wins_vld", 64'(do_vld), 64'd0);
    chk("rst_wins_rdy", 64'(rdy),    64'd1);

    run_frame(4'b1011, 12'd100, 100, 100, "t1", got);
    chk("t1_first8", 64'(got[7:0]), 64'(8'b1000_1011));

    run_frame(4'b0000, 12'd0, 100, 100, "t2", got);
    chk("t2_zero", 64'(got), 64'd0);

    run_frame(4'b1101, 12'd0, 100, 100, "t3", got);
    chk("t3_tail12", 64'(got[47:36]),
        64'(12'(model_encode(model_field(4'b1101, 12'd0)) >> 36)));

    // mid-frame start ignored, then a start in the cycle rdy rises
    run_frame(4'b0110, 12'hA5C, 10, 100, "t4a", got);
    run_frame(4'b1001, 12'h3F1, 100, 100, "t4b", got);

    // abort at coded bit 20, then a clean frame
    run_frame(4'b1111, 12'hFFF, 100, 20, "t5a", got);
    run_frame(4'b0101, 12'h123, 100, 100, "t5b", got);

    for (int n = 0; n < 1000; n++) begin
      r = 4'($urandom_range(0, 15));
      l = 12'($urandom);
      run_frame(r, l, 100, 100, "rnd", got);
      chk("rnd_loop", 64'(loop_decode(got)), 64'(model_field(r, l)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
